// File: rtl/motor_cmd_arbiter.sv
// Motor command register block.
// Holds the four duty registers, the drive code and the allstop mask, and
// arbitrates register writes between the host (SPI decode) and the local PID
// loop. A host-link watchdog zeroes the duties and raises every allstop bit
// when the host goes quiet. The block stays TRIPPED until the host explicitly
// re-arms it.
module motor_cmd_arbiter #(
    parameter logic [23:0] WDT_CYCLES           = 24'd5000000,
    parameter logic [7:0]  MOT_DRIVE_CODE_START = 8'd0,
    parameter logic [4:0]  MOT_ALLSTOP_START    = 5'd0
) (
    input  logic        SYS_CLK,
    input  logic        SYS_RST,
    // host write port
    input  logic        host_wr_valid,
    input  logic [9:0]  host_wr_addr,
    input  logic [15:0] host_wr_data,
    output logic        host_wr_ready,
    input  logic        host_activity,
    // PID write port
    input  logic        pid_wr_valid,
    input  logic [9:0]  pid_wr_addr,
    input  logic [15:0] pid_wr_data,
    output logic        pid_wr_ready,
    // command registers
    output logic [11:0] mot_duty0,
    output logic [11:0] mot_duty1,
    output logic [11:0] mot_duty2,
    output logic [11:0] mot_duty3,
    output logic [7:0]  mot_drive_code,
    output logic [4:0]  mot_allstop,
    // status
    output logic        wdt_tripped,
    output logic        pid_reject,
    output logic        addr_err
);

    localparam int         NUM_DUTY     = 4;
    localparam logic [9:0] ADDR_DUTY0   = 10'd33;
    localparam logic [9:0] ADDR_DRIVE   = 10'd39;
    localparam logic [9:0] ADDR_ALLSTOP = 10'd40;
    localparam logic [4:0] ALLSTOP_ALL  = 5'h1F;
    localparam bit         WDT_EN       = (WDT_CYCLES != 24'd0);

    typedef enum logic {
        ST_ARMED   = 1'b0,
        ST_TRIPPED = 1'b1
    } state_t;

    typedef enum logic {
        GRANT_HOST = 1'b0,
        GRANT_PID  = 1'b1
    } grant_t;

    // registered state
    state_t      r_state;
    grant_t      r_last_grant;
    logic [23:0] r_wdt_cnt;
    logic [7:0]  r_drive_code;
    logic [4:0]  r_allstop;
    logic        r_pid_reject;
    logic        r_addr_err;

    // combinational handshake / decode
    logic                         w_host_ready;
    logic                         w_pid_ready;
    logic                         w_host_xfer;
    logic                         w_pid_xfer;
    logic                         w_any_xfer;
    logic [9:0]                   w_xfer_addr;
    logic [11:0]                  w_xfer_data;
    logic [NUM_DUTY-1:0]          w_sel_duty;
    logic                         w_sel_drive;
    logic                         w_sel_allstop;
    logic                         w_mapped;
    logic                         w_wr_en;
    logic                         w_wdt_clear;
    logic                         w_wdt_trip;
    logic                         w_rearm;
    logic [NUM_DUTY-1:0][11:0]    w_duty;
    logic                         w_unused_data;

    // Only the low 12 data bits ever reach a register.
    assign w_unused_data = ^{host_wr_data[15:12], pid_wr_data[15:12]};

    // Round-robin grant: a lone requester always wins; on a conflict the
    // requester that did not win last time goes first. Nothing is accepted
    // while reset is asserted, so a transfer racing reset is simply dropped.
    always_comb begin
        w_host_ready = 1'b0;
        w_pid_ready  = 1'b0;
        if (!SYS_RST) begin
            if (host_wr_valid && (!pid_wr_valid || r_last_grant == GRANT_PID)) begin
                w_host_ready = 1'b1;
            end
            if (pid_wr_valid && (!host_wr_valid || r_last_grant == GRANT_HOST)) begin
                w_pid_ready = 1'b1;
            end
        end
    end

    assign host_wr_ready = w_host_ready;
    assign pid_wr_ready  = w_pid_ready;
    assign w_host_xfer   = w_host_ready;
    assign w_pid_xfer    = w_pid_ready;
    assign w_any_xfer    = w_host_xfer | w_pid_xfer;

    // Select the address/data of whichever requester transfers this cycle.
    always_comb begin
        w_xfer_addr = pid_wr_addr;
        w_xfer_data = pid_wr_data[11:0];
        if (w_host_xfer) begin
            w_xfer_addr = host_wr_addr;
            w_xfer_data = host_wr_data[11:0];
        end
    end

    assign w_sel_drive   = (w_xfer_addr == ADDR_DRIVE);
    assign w_sel_allstop = (w_xfer_addr == ADDR_ALLSTOP);
    assign w_mapped      = (|w_sel_duty) | w_sel_drive | w_sel_allstop;

    // PID writes only land while ARMED; host writes always land.
    assign w_wr_en = w_host_xfer | (w_pid_xfer & (r_state == ST_ARMED));

    // Any host traffic (heartbeat or an actual write) proves the link is up.
    assign w_wdt_clear = host_activity | w_host_xfer;
    assign w_wdt_trip  = WDT_EN && (r_wdt_cnt == WDT_CYCLES) && !w_wdt_clear;

    // Host clearing allstop bit 4 is the explicit "resume" command.
    assign w_rearm = (r_state == ST_TRIPPED) && w_host_xfer && w_sel_allstop
                     && !host_wr_data[4];

    // Host-silence counter, saturating at the trip limit.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST || !WDT_EN) begin
            r_wdt_cnt <= 24'd0;
        end else if (w_wdt_clear) begin
            r_wdt_cnt <= 24'd0;
        end else if (r_wdt_cnt < WDT_CYCLES) begin
            r_wdt_cnt <= r_wdt_cnt + 24'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DUTY; gi++) begin : g_duty
            logic [11:0] r_duty;

            assign w_sel_duty[gi] = (w_xfer_addr == ADDR_DUTY0 + 10'(gi));

            // Duty register: a watchdog trip overrides any write in flight.
            always_ff @(posedge SYS_CLK) begin
                if (SYS_RST) begin
                    r_duty <= 12'd0;
                end else if (w_wdt_trip) begin
                    r_duty <= 12'd0;
                end else if (w_wr_en && w_sel_duty[gi]) begin
                    r_duty <= w_xfer_data;
                end
            end

            assign w_duty[gi] = r_duty;
        end
    endgenerate

    assign mot_duty0 = w_duty[0];
    assign mot_duty1 = w_duty[1];
    assign mot_duty2 = w_duty[2];
    assign mot_duty3 = w_duty[3];

    // Drive code register; the watchdog leaves it alone.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            r_drive_code <= MOT_DRIVE_CODE_START;
        end else if (w_wr_en && w_sel_drive) begin
            r_drive_code <= w_xfer_data[7:0];
        end
    end

    // Allstop register: a trip forces every channel to stop.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            r_allstop <= MOT_ALLSTOP_START;
        end else if (w_wdt_trip) begin
            r_allstop <= ALLSTOP_ALL;
        end else if (w_wr_en && w_sel_allstop) begin
            r_allstop <= w_xfer_data[4:0];
        end
    end

    assign mot_drive_code = r_drive_code;
    assign mot_allstop    = r_allstop;

    // Watchdog state, grant history and the one-cycle status pulses.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            r_state      <= ST_ARMED;
            r_last_grant <= GRANT_PID;
            r_pid_reject <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            if (w_wdt_trip) begin
                r_state <= ST_TRIPPED;
            end else if (w_rearm) begin
                r_state <= ST_ARMED;
            end

            if (w_host_xfer) begin
                r_last_grant <= GRANT_HOST;
            end else if (w_pid_xfer) begin
                r_last_grant <= GRANT_PID;
            end

            r_pid_reject <= w_pid_xfer && (r_state == ST_TRIPPED) && w_mapped;
            r_addr_err   <= w_any_xfer && !w_mapped;
        end
    end

    assign wdt_tripped = (r_state == ST_TRIPPED);
    assign pid_reject  = r_pid_reject;
    assign addr_err    = r_addr_err;

endmodule

// File: doc/motor_cmd_arbiter.md
Name: motor_cmd_arbiter

Overview:
Owns the motor command registers (duty 0-3, drive code, allstop) and arbitrates writes to them between two requesters: the host path (SPI write decode) and the local closed-loop path (PID). A host-link watchdog forces a safe stop if the host goes silent. The block sits between the SPI register interface and the motor PWM/H-bridge logic.

Parameters:
WDT_CYCLES, 24'd5000000, SYS_CLK cycles of host silence before trip; 0 disables the watchdog.
MOT_DRIVE_CODE_START, 8'd0, reset value of mot_drive_code.
MOT_ALLSTOP_START, 5'd0, reset value of mot_allstop.

Ports:
SYS_CLK  input  1  system clock, all logic on posedge.
SYS_RST  input  1  synchronous, active-high reset.
host_wr_valid  input  1  host write request.
host_wr_addr  input  10  host register address.
host_wr_data  input  16  host write data.
host_wr_ready  output  1  host write accepted this cycle.
host_activity  input  1  one-cycle pulse per received SPI word (heartbeat).
pid_wr_valid  input  1  PID write request.
pid_wr_addr  input  10  PID register address.
pid_wr_data  input  16  PID write data.
pid_wr_ready  output  1  PID write accepted this cycle.
mot_duty0..mot_duty3  output  12 each  motor duty registers.
mot_drive_code  output  8  drive code register.
mot_allstop  output  5  allstop register.
wdt_tripped  output  1  high while in the TRIPPED state.
pid_reject  output  1  one-cycle pulse when an accepted PID write is dropped.
addr_err  output  1  one-cycle pulse when an accepted write targets an unmapped address.

Behaviour:
- Reset (SYS_RST=1 at a clock edge):
  - All duties = 0.
  - mot_drive_code = MOT_DRIVE_CODE_START; mot_allstop = MOT_ALLSTOP_START.
  - State = ARMED; wdt counter = 0.
  - last_grant = PID, so the host wins the first conflict.
  - pid_reject = addr_err = 0.
  - Reset mid-transfer discards the transfer.
- Register map (data LSB-aligned, upper bits ignored):
  - 33-36 → mot_duty0-3 [11:0]
  - 39 → mot_drive_code [7:0]
  - 40 → mot_allstop [4:0]
  - Any other address: accepted, no register change, addr_err pulses the next cycle.
- Handshake:
  - *_wr_ready is combinational from the valids and last_grant.
  - A transfer occurs when valid && ready. At most one ready is high per cycle.
  - A requester holds valid, addr and data stable until ready.
  - The register update is visible on the cycle after the transfer (1-cycle latency).
- Arbitration:
  - Only one valid: it is granted immediately.
  - Both valid: the requester opposite last_grant is granted.
  - last_grant updates on every transfer.
- Watchdog (skipped entirely when WDT_CYCLES==0):
  - Counter saturates at WDT_CYCLES.
  - Cleared on host_activity or any host transfer; otherwise increments each cycle.
  - When the counter == WDT_CYCLES and there is no clear that cycle: next edge sets state TRIPPED, all duties = 0, mot_allstop = 5'h1F.
  - A clear in the same cycle as the limit wins, and no trip occurs.
  - A host transfer coinciding with the trip edge: the trip values take priority over the host write for duties and allstop.
- TRIPPED state:
  - PID transfers to 33-36, 39 or 40 still handshake (ready per arbitration), but are dropped; pid_reject pulses the next cycle.
  - Host writes apply normally.
  - A host write to 40 with data[4]==0 writes allstop, returns to ARMED and clears the counter.
  - A host write to 40 with data[4]==1 stays TRIPPED.
- ARMED state: PID writes apply exactly as host writes do.
- wdt_tripped is registered and equals (state==TRIPPED).

Test Plan:
- Reset, then host writes addr 33 data 16'hF123 → host_wr_ready=1 the same cycle; mot_duty0=12'h123 next cycle; other registers unchanged.
- Host and PID both valid for 4 cycles (host addr 34 data 100, PID addr 34 data 200, each dropping valid after its grant) → grants go host then PID; mot_duty1 ends at 200; ready is never high for both at once.
- WDT_CYCLES=10, no activity, duty2=500 → on edge 11 after reset: wdt_tripped=1, duty2=0, mot_allstop=5'h1F.
- While tripped, PID writes addr 35 data 300 → pid_wr_ready=1, pid_reject pulses once, mot_duty2 stays 0. Then host writes addr 40 data 0 → mot_allstop=0, wdt_tripped=0 next cycle.
- host_activity pulsed every 9 cycles with WDT_CYCLES=10 for 1000 cycles → no trip. Pulse exactly on the limit cycle → no trip.
- Host writes addr 50 → addr_err pulses 1 cycle, all registers unchanged. SYS_RST asserted mid-stream → all outputs return to reset values on the next edge.
